// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered release of per-block active-low resets after a
// global reset or a software/watchdog reset request.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SW_RST_REQ,
    input  logic                  WDOG_RST_REQ,
    output logic [NUM_STAGES-1:0] STAGE_RST_,
    output logic                  RST_DONE,
    output logic [1:0]            RST_CAUSE,
    output logic [7:0]            RST_COUNT
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    // Index must also hold NUM_STAGES, the "all stages released" value.
    localparam int unsigned IDX_W   = $clog2(NUM_STAGES + 1);

    localparam logic [1:0] CAUSE_GLOBAL = 2'b00;
    localparam logic [1:0] CAUSE_SW     = 2'b01;
    localparam logic [1:0] CAUSE_WDOG   = 2'b10;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic [1:0]            cause_q, cause_d;
    logic [7:0]            count_q, count_d;
    logic                  req;

    assign req = SW_RST_REQ | WDOG_RST_REQ;

    // Next-state and registered-output values; requests preempt every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        done_d  = done_q;
        cause_d = cause_q;
        count_d = count_q;

        if (req) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            stage_d = '0;
            done_d  = 1'b0;
            // Cause/count only move when a new sequence actually starts.
            if (state_q != ST_ASSERT) begin
                cause_d = WDOG_RST_REQ ? CAUSE_WDOG : CAUSE_SW;
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end
            end
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        stage_d[0] = 1'b1;
                        state_d    = ST_RELEASE;
                        idx_d      = IDX_W'(1);
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                        cnt_d = '0;
                        if (idx_q < IDX_W'(NUM_STAGES)) begin
                            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                                if (idx_q == IDX_W'(k)) begin
                                    stage_d[k] = 1'b1;
                                end
                            end
                            idx_d = idx_q + IDX_W'(1);
                        end else begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_ASSERT;
                end
            endcase
        end
    end

    // State and output registers; global reset overrides everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            cause_q <= CAUSE_GLOBAL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    assign STAGE_RST_ = stage_q;
    assign RST_DONE   = done_q;
    assign RST_CAUSE  = cause_q;
    assign RST_COUNT  = count_q;

endmodule
